// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: command-driven sequencer for a WIDTH-bit load/shift/rotate register.
// Accepts one command at a time over valid/ready and steps the register one position per clock.
// Defining SHREG_SEQ_ABORT_EN adds the abort input and the aborted status output.
module shift_reg_sequencer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             serial_in,
   output logic [WIDTH-1:0] Q,
   output logic             serial_out,
   output logic             busy,
`ifdef SHREG_SEQ_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             done
);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      OpLoad = 2'b00,
      OpShl  = 2'b01,
      OpShr  = 2'b10,
      OpRotl = 2'b11
   } op_e;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
`ifdef SHREG_SEQ_ABORT_EN
   logic             aborted_q, aborted_d;
`endif

   // Result of one single-position step of the latched shift/rotate operation
   logic [WIDTH-1:0] step_q;
   logic             step_out;

   // Single-step datapath: the value Q and serial_out would take on a shift edge
   always_comb begin
      step_q   = q_q;
      step_out = sout_q;
      unique case (op_q)
         OpShl: begin
            step_q   = {q_q[WIDTH-2:0], serial_in};
            step_out = q_q[WIDTH-1];
         end
         OpShr: begin
            step_q   = {serial_in, q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         OpRotl: begin
            step_q   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            step_out = q_q[WIDTH-1];
         end
         default: begin
            // LOAD never reaches the shift state; hold the register
            step_q   = q_q;
            step_out = sout_q;
         end
      endcase
   end

   // Next-state and datapath update for the command sequencer
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      q_d       = q_q;
      sout_d    = sout_q;
`ifdef SHREG_SEQ_ABORT_EN
      aborted_d = aborted_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d   = op_e'(cmd_op);
               cnt_d  = cmd_count;
               data_d = cmd_data;
               if (op_e'(cmd_op) == OpLoad) begin
                  state_d = StLoad;
               end else if (cmd_count != '0) begin
                  state_d = StShift;
               end else begin
                  // Zero-length shift: complete without touching the register
                  state_d = StDone;
               end
            end
         end
         StLoad: begin
            q_d     = data_q;
            state_d = StDone;
         end
         StShift: begin
`ifdef SHREG_SEQ_ABORT_EN
            if (abort) begin
               // Abort wins over the step scheduled for this edge
               aborted_d = 1'b1;
               state_d   = StDone;
            end else begin
               q_d    = step_q;
               sout_d = step_out;
               cnt_d  = cnt_q - CntOne;
               if (cnt_q == CntOne) begin
                  state_d = StDone;
               end
            end
`else
            q_d    = step_q;
            sout_d = step_out;
            cnt_d  = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
               state_d = StDone;
            end
`endif
         end
         StDone: begin
`ifdef SHREG_SEQ_ABORT_EN
            aborted_d = 1'b0;
`endif
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous active-high reset
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q   <= StIdle;
         op_q      <= OpLoad;
         cnt_q     <= '0;
         data_q    <= '0;
         q_q       <= '0;
         sout_q    <= 1'b0;
`ifdef SHREG_SEQ_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         q_q       <= q_d;
         sout_q    <= sout_d;
`ifdef SHREG_SEQ_ABORT_EN
         aborted_q <= aborted_d;
`endif
      end
   end

   // Status outputs decode directly from the state register
   assign cmd_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign Q          = q_q;
   assign serial_out = sout_q;
`ifdef SHREG_SEQ_ABORT_EN
   assign aborted    = aborted_q;
`endif

endmodule
